// File: rtl/pixel_unpack.sv
// pixel_unpack: splits each accepted WORD_W-bit word into LANES = WORD_W/PIX_W
// pixels, emitted one per accepted pixel transfer, in either lane order.
//
// Handshake: a word transfer happens on a cycle where in_valid && in_ready.
// A pixel transfer happens on a cycle where out_valid && out_ready. A producer
// holds valid and its payload until the transfer happens. in_ready is also
// high on the final lane while out_ready is high, so a new word can load with
// no bubble.
//
// Optional feature: define PIXEL_UNPACK_COUNT_EN to add the 32-bit pix_count
// output. It counts pixel transfers and clears on the cycle after an out_last
// transfer. Without the macro, that port and its logic do not exist.
//
// WORD_W must be an integer multiple of PIX_W, and LANES must be >= 2.
// dbg_state exposes the FSM state (0 = IDLE, 1 = SHIFT) so checkers can bind to it.
module pixel_unpack #(
  parameter int WORD_W = 32,
  parameter int PIX_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              msb_first,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_word,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_valid,
  output logic [PIX_W-1:0]  out_pix,
  output logic              out_last,
  input  logic              out_ready,
`ifdef PIXEL_UNPACK_COUNT_EN
  output logic [31:0]       pix_count,
`endif
  output logic              dbg_state
);

  localparam int LANES = WORD_W / PIX_W;
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   word_q;
  logic                last_q;
  logic                msb_q;
  logic [IDX_W-1:0]    idx_q;
  logic [IDX_W-1:0]    lane_sel;
  logic                word_xfer;
  logic                pix_xfer;
  logic                at_last_lane;

  assign at_last_lane = (idx_q == LAST_IDX);
  assign word_xfer    = in_valid && in_ready;
  assign pix_xfer     = out_valid && out_ready;
  assign dbg_state    = state_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: load a word from IDLE; leave SHIFT after the last lane
  // unless a new word is reloaded in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (word_xfer) state_d = ST_SHIFT;
      ST_SHIFT: if (pix_xfer && at_last_lane && !word_xfer) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs. All of them are masked while reset is asserted.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    if (state_q == ST_SHIFT) begin
      out_valid = 1'b1;
      out_last  = last_q && at_last_lane;
      in_ready  = at_last_lane && out_ready;
    end else begin
      in_ready  = 1'b1;
    end
    if (rst) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
    end
  end

  // Held word, flags and lane index. They stay frozen unless a transfer occurs.
  // In IDLE the word and index are kept, so out_pix keeps showing the last lane.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      last_q <= 1'b0;
      msb_q  <= 1'b0;
      idx_q  <= '0;
    end else if (word_xfer) begin
      word_q <= in_word;
      last_q <= in_last;
      msb_q  <= msb_first;
      idx_q  <= '0;
    end else if (pix_xfer && !at_last_lane) begin
      idx_q  <= idx_q + 1'b1;
    end
  end

  // Lane select. It uses only registered state, so msb_first changes after
  // accept have no effect on the held word.
  always_comb begin
    lane_sel = msb_q ? (LAST_IDX - idx_q) : idx_q;
    out_pix  = '0;
    for (int l = 0; l < LANES; l++) begin
      if (lane_sel == IDX_W'(l)) out_pix = word_q[l*PIX_W +: PIX_W];
    end
  end

`ifdef PIXEL_UNPACK_COUNT_EN
  logic [31:0] cnt_q;
  logic        clr_q;

  assign pix_count = cnt_q;

  // Pixel transfer counter. It clears one cycle after an out_last transfer,
  // and a pixel transferred in that same cycle starts the new count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      clr_q <= 1'b0;
    end else begin
      clr_q <= pix_xfer && out_last;
      if (clr_q)         cnt_q <= pix_xfer ? 32'd1 : 32'd0;
      else if (pix_xfer) cnt_q <= cnt_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pixel_unpack.sv
// Directed bench for pixel_unpack with default parameters (4 lanes of 8 bits).
// Inputs change 1 time unit after a rising edge, and outputs are checked at the same point.
module tb_pixel_unpack;

  logic        clk;
  logic        rst;
  logic        msb_first;
  logic        in_valid;
  logic [31:0] in_word;
  logic        in_last;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_pix;
  logic        out_last;
  logic        out_ready;
  logic        dbg_state;
`ifdef PIXEL_UNPACK_COUNT_EN
  logic [31:0] pix_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pixel_unpack #(.WORD_W(32), .PIX_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .msb_first (msb_first),
    .in_valid  (in_valid),
    .in_word   (in_word),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pix   (out_pix),
    .out_last  (out_last),
    .out_ready (out_ready),
`ifdef PIXEL_UNPACK_COUNT_EN
    .pix_count (pix_count),
`endif
    .dbg_state (dbg_state)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_word = '0; in_last = 1'b0;
    msb_first = 1'b0; out_ready = 1'b1;
    tick(); tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++;
    if (out_pix !== 8'h00) begin n_fail++; $display("FAIL reset_out_pix got %h want 00", out_pix); end
    n_checks++;
    if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got %b want 0", out_last); end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_checks++;
    if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL reset_state got %b want 0", dbg_state); end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready got %b want 1", in_ready); end
  endtask

  // The word is presented for one accept cycle. The pixels then follow on consecutive cycles.
  task automatic run_word(input string name, input logic [31:0] w, input logic msb,
                          input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] exp_pix[4];
    exp_pix[0] = e0; exp_pix[1] = e1; exp_pix[2] = e2; exp_pix[3] = e3;
    in_valid = 1'b1; in_word = w; msb_first = msb; in_last = 1'b0; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; in_word = 32'hDEADBEEF;
    msb_first = ~msb;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL %s_valid[%0d] got %b want 1", name, k, out_valid); end
      n_checks++;
      if (out_pix !== exp_pix[k]) begin n_fail++; $display("FAIL %s_pix[%0d] got %h want %h", name, k, out_pix, exp_pix[k]); end
      tick();
    end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_idle_valid got %b want 0", name, out_valid); end
    n_checks++;
    if (out_pix !== exp_pix[3]) begin n_fail++; $display("FAIL %s_idle_pix got %h want %h", name, out_pix, exp_pix[3]); end
    n_checks++;
    if (out_last !== 1'b0) begin n_fail++; $display("FAIL %s_idle_last got %b want 0", name, out_last); end
  endtask

  task automatic test_lsb_first();
    run_word("lsb", 32'h44332211, 1'b0, 8'h11, 8'h22, 8'h33, 8'h44);
  endtask

  task automatic test_msb_first();
    run_word("msb", 32'hAABBCCDD, 1'b1, 8'hAA, 8'hBB, 8'hCC, 8'hDD);
  endtask

  task automatic test_back_to_back();
    logic exp_rdy;
    in_valid = 1'b1; in_word = 32'h04030201; msb_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_first_ready got %b want 1", in_ready); end
    tick();
    in_word = 32'h08070605;
    for (int k = 0; k < 8; k++) begin
      exp_rdy = (k == 3 || k == 7);
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d] got %b want 1", k, out_valid); end
      n_checks++;
      if (out_pix !== 8'(k + 1)) begin n_fail++; $display("FAIL b2b_pix[%0d] got %h want %h", k, out_pix, 8'(k + 1)); end
      n_checks++;
      if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL b2b_in_ready[%0d] got %b want %b", k, in_ready, exp_rdy); end
      tick();
      if (k == 3) in_valid = 1'b0;
    end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end_valid got %b want 0", out_valid); end
    n_checks++;
    if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL b2b_end_state got %b want 0", dbg_state); end
  endtask

  task automatic test_stall();
    logic [7:0] exp_pix[6];
    logic       rdy_seq[6];
    exp_pix[0] = 8'h01; exp_pix[1] = 8'h02; exp_pix[2] = 8'h02;
    exp_pix[3] = 8'h02; exp_pix[4] = 8'h03; exp_pix[5] = 8'h04;
    rdy_seq[0] = 1'b1; rdy_seq[1] = 1'b0; rdy_seq[2] = 1'b0;
    rdy_seq[3] = 1'b1; rdy_seq[4] = 1'b1; rdy_seq[5] = 1'b1;
    in_valid = 1'b1; in_word = 32'h04030201; msb_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      out_ready = rdy_seq[k];
      #1;
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d] got %b want 1", k, out_valid); end
      n_checks++;
      if (out_pix !== exp_pix[k]) begin n_fail++; $display("FAIL stall_pix[%0d] got %h want %h", k, out_pix, exp_pix[k]); end
      tick();
    end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_end_valid got %b want 0", out_valid); end
    out_ready = 1'b1;
  endtask

  task automatic test_last();
    logic [7:0] exp_pix[4];
    logic       exp_last;
    exp_pix[0] = 8'hAA; exp_pix[1] = 8'hBB; exp_pix[2] = 8'hCC; exp_pix[3] = 8'hDD;
    rst = 1'b1; tick(); rst = 1'b0;
    in_valid = 1'b1; in_word = 32'hDDCCBBAA; msb_first = 1'b0; in_last = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_last = (k == 3);
      if (k == 3) begin
        out_ready = 1'b0;
        #1;
        n_checks++;
        if (out_last !== 1'b1) begin n_fail++; $display("FAIL last_stalled got %b want 1", out_last); end
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL last_stall_in_ready got %b want 0", in_ready); end
        tick();
        out_ready = 1'b1;
        #1;
      end
      n_checks++;
      if (out_pix !== exp_pix[k]) begin n_fail++; $display("FAIL last_pix[%0d] got %h want %h", k, out_pix, exp_pix[k]); end
      n_checks++;
      if (out_last !== exp_last) begin n_fail++; $display("FAIL last_flag[%0d] got %b want %b", k, out_last, exp_last); end
`ifdef PIXEL_UNPACK_COUNT_EN
      n_checks++;
      if (pix_count !== 32'(k)) begin n_fail++; $display("FAIL count[%0d] got %0d want %0d", k, pix_count, k); end
`endif
      tick();
    end
    n_checks++;
    if (out_last !== 1'b0) begin n_fail++; $display("FAIL last_idle_flag got %b want 0", out_last); end
`ifdef PIXEL_UNPACK_COUNT_EN
    n_checks++;
    if (pix_count !== 32'd4) begin n_fail++; $display("FAIL count_full got %0d want 4", pix_count); end
    tick();
    n_checks++;
    if (pix_count !== 32'd0) begin n_fail++; $display("FAIL count_clear got %0d want 0", pix_count); end
`endif
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_word = 32'h44332211; msb_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    n_checks++;
    if (out_pix !== 8'h33) begin n_fail++; $display("FAIL rmid_pre_pix got %h want 33", out_pix); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b want 0", out_valid); end
    n_checks++;
    if (out_pix !== 8'h00) begin n_fail++; $display("FAIL rmid_pix got %h want 00", out_pix); end
    tick(); tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_later_valid got %b want 0", out_valid); end
    run_word("rmid_new", 32'h88776655, 1'b0, 8'h55, 8'h66, 8'h77, 8'h88);
  endtask

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_back_to_back();
    test_stall();
    test_last();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
